// File: rtl/riscv_mem_arbiter.sv
// Fetch/data arbiter onto one memory port, one transaction outstanding.
// Optional starvation guard: define RISCV_ARB_STARVE_GUARD_EN.
module riscv_mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        if_req_valid,
   input  logic [63:0] if_req_addr,
   output logic        if_req_ready,
   output logic        if_rsp_valid,
   output logic [31:0] if_rsp_data,
   input  logic        d_req_valid,
   input  logic        d_req_we,
   input  logic [63:0] d_req_addr,
   input  logic [63:0] d_req_wdata,
   input  logic [7:0]  d_req_wstrb,
   output logic        d_req_ready,
   output logic        d_rsp_valid,
   output logic [63:0] d_rsp_rdata,
   output logic        mem_req_valid,
   output logic        mem_req_we,
   output logic [63:0] mem_req_addr,
   output logic [63:0] mem_req_wdata,
   output logic [7:0]  mem_req_wstrb,
   input  logic        mem_req_ready,
   input  logic        mem_rsp_valid,
   input  logic [63:0] mem_rsp_rdata
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2
   } state_t;

   state_t state;
   logic   owner_d;
   logic   idle;
   logic   force_f;
   logic   grant_d;
   logic   grant_f;
   logic   rsp_fire;

`ifdef RISCV_ARB_STARVE_GUARD_EN
   localparam int unsigned CW = $clog2(STARVE_LIMIT + 2);
   logic [CW-1:0] starve_cnt;

   assign force_f = (starve_cnt == CW'(STARVE_LIMIT));

   // Count back-to-back data grants that left a fetch waiting
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= '0;
      end else if (grant_d && if_req_valid) begin
         if (starve_cnt != CW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
      end else if (grant_d || grant_f) begin
         starve_cnt <= '0;
      end
   end
`else
   assign force_f = 1'b0;
`endif

   // Grants are combinational in IDLE; readies are held low in reset
   assign idle     = resetn && (state == IDLE);
   assign grant_d  = idle && d_req_valid && !(force_f && if_req_valid);
   assign grant_f  = idle && if_req_valid && !grant_d;
   assign d_req_ready  = grant_d;
   assign if_req_ready = grant_f;

   // Response is forwarded in the cycle memory returns it
   assign rsp_fire     = (state == WAIT_RSP) && mem_rsp_valid;
   assign d_rsp_valid  = rsp_fire && owner_d;
   assign if_rsp_valid = rsp_fire && !owner_d;
   assign d_rsp_rdata  = d_rsp_valid ? mem_rsp_rdata : 64'd0;
   assign if_rsp_data  = !if_rsp_valid ? 32'd0 :
                         mem_req_addr[2] ? mem_rsp_rdata[63:32] :
                                           mem_rsp_rdata[31:0];

   // Transaction FSM with registered memory request fields
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         owner_d       <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         mem_req_wstrb <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant_d) begin
                  state         <= REQ;
                  owner_d       <= 1'b1;
                  mem_req_valid <= 1'b1;
                  mem_req_we    <= d_req_we;
                  mem_req_addr  <= d_req_addr;
                  mem_req_wdata <= d_req_wdata;
                  mem_req_wstrb <= d_req_wstrb;
               end else if (grant_f) begin
                  state         <= REQ;
                  owner_d       <= 1'b0;
                  mem_req_valid <= 1'b1;
                  mem_req_we    <= 1'b0;
                  mem_req_addr  <= if_req_addr;
                  mem_req_wdata <= '0;
                  mem_req_wstrb <= '0;
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               if (mem_rsp_valid)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter.
// Follows RISCV_ARB_STARVE_GUARD_EN for the grant-sequence expectations.
module tb_riscv_mem_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        if_req_valid;
   logic [63:0] if_req_addr;
   logic        if_req_ready;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;
   logic        d_req_valid;
   logic        d_req_we;
   logic [63:0] d_req_addr;
   logic [63:0] d_req_wdata;
   logic [7:0]  d_req_wstrb;
   logic        d_req_ready;
   logic        d_rsp_valid;
   logic [63:0] d_rsp_rdata;
   logic        mem_req_valid;
   logic        mem_req_we;
   logic [63:0] mem_req_addr;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wstrb;
   logic        mem_req_ready;
   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_rdata;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   riscv_mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .resetn(resetn),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
      .if_req_ready(if_req_ready), .if_rsp_valid(if_rsp_valid),
      .if_rsp_data(if_rsp_data),
      .d_req_valid(d_req_valid), .d_req_we(d_req_we),
      .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
      .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
      .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_req_wstrb(mem_req_wstrb), .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Start a new cycle: memory handshakes default low
   task automatic nxt();
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
   endtask

   // After a grant cycle: accept request, then return rdata
   task automatic serve(input logic [63:0] rdata);
      nxt();
      mem_req_ready = 1'b1;
      #1;
      chk("serve_mreq_v", mem_req_valid, 1);
      nxt();
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = rdata;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] exp_g;
      resetn        = 1'b0;
      if_req_valid  = 1'b0;
      if_req_addr   = '0;
      d_req_valid   = 1'b0;
      d_req_we      = 1'b0;
      d_req_addr    = '0;
      d_req_wdata   = '0;
      d_req_wstrb   = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;

      // Reset: outputs forced low even with requests pending
      repeat (2) nxt();
      if_req_valid = 1'b1;
      d_req_valid  = 1'b1;
      mem_rsp_valid = 1'b1;
      #1;
      chk("rst_ready", {if_req_ready, d_req_ready}, 0);
      chk("rst_rspv", {if_rsp_valid, d_rsp_valid}, 0);
      chk("rst_mreq", {mem_req_valid, mem_req_we, mem_req_wstrb}, 0);
      chk("rst_addr", mem_req_addr, 0);
      chk("rst_data", {if_rsp_data, d_rsp_rdata[31:0]}, 0);
      if_req_valid = 1'b0;
      d_req_valid  = 1'b0;

      // Fetch only, granted right after reset release
      nxt();
      resetn       = 1'b1;
      if_req_valid = 1'b1;
      if_req_addr  = 64'h8000_0004;
      #1;
      chk("f1_ready", if_req_ready, 1);
      chk("f1_mreqv0", mem_req_valid, 0);
      nxt();
      if_req_valid  = 1'b0;
      mem_req_ready = 1'b1;
      #1;
      chk("f1_mreqv", mem_req_valid, 1);
      chk("f1_addr", mem_req_addr, 64'h8000_0004);
      chk("f1_we_strb", {mem_req_we, mem_req_wstrb}, 0);
      chk("f1_rspv_early", if_rsp_valid, 0);
      nxt();
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 64'h1111_2222_3333_4444;
      #1;
      chk("f1_rspv", if_rsp_valid, 1);
      chk("f1_data", if_rsp_data, 32'h1111_2222);
      chk("f1_drsp", d_rsp_valid, 0);
      nxt();
      #1;
      chk("f1_rspv_off", if_rsp_valid, 0);

      // Simultaneous store and fetch: data wins first
      if_req_valid = 1'b1;
      if_req_addr  = 64'h8000_0000;
      d_req_valid  = 1'b1;
      d_req_we     = 1'b1;
      d_req_addr   = 64'h100;
      d_req_wdata  = 64'hDEAD_BEEF_CAFE_F00D;
      d_req_wstrb  = 8'h0F;
      #1;
      chk("sim_grant", {d_req_ready, if_req_ready}, 2'b10);
      serve(64'h0);
      d_req_valid = 1'b0;
      chk("sim_st_we", mem_req_we, 1);
      chk("sim_st_strb", mem_req_wstrb, 8'h0F);
      chk("sim_st_addr", mem_req_addr, 64'h100);
      chk("sim_st_wdata", mem_req_wdata, 64'hDEAD_BEEF_CAFE_F00D);
      chk("sim_st_rsp", {d_rsp_valid, if_rsp_valid}, 2'b10);
      nxt();
      #1;
      chk("sim_f_grant", {d_req_ready, if_req_ready}, 2'b01);
      serve(64'hAAAA_BBBB_CCCC_DDDD);
      if_req_valid = 1'b0;
      chk("sim_f_fields", {mem_req_we, mem_req_wstrb}, 0);
      chk("sim_f_addr", mem_req_addr, 64'h8000_0000);
      chk("sim_f_rsp", {d_rsp_valid, if_rsp_valid}, 2'b01);
      chk("sim_f_data", if_rsp_data, 32'hCCCC_DDDD);

      // Backpressure with a stray response during REQ
      nxt();
      d_req_valid  = 1'b1;
      d_req_we     = 1'b0;
      d_req_addr   = 64'h200;
      d_req_wstrb  = 8'hFF;
      if_req_valid = 1'b1;
      if_req_addr  = 64'h8000_0008;
      #1;
      chk("bp_grant", {d_req_ready, if_req_ready}, 2'b10);
      for (int k = 0; k < 5; k++) begin
         nxt();
         if (k == 0) d_req_valid = 1'b0;
         mem_rsp_valid = (k == 2);
         mem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
         #1;
         chk("bp_mreqv", mem_req_valid, 1);
         chk("bp_fields", {mem_req_we, mem_req_wstrb}, 9'h0FF);
         chk("bp_addr", mem_req_addr, 64'h200);
         chk("bp_nogrant", {d_req_ready, if_req_ready}, 0);
         chk("bp_norsp", {d_rsp_valid, if_rsp_valid}, 0);
      end
      nxt();
      mem_req_ready = 1'b1;
      #1;
      nxt();
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 64'h0123_4567_89AB_CDEF;
      #1;
      chk("bp_ld_rsp", {d_rsp_valid, if_rsp_valid}, 2'b10);
      chk("bp_ld_data", d_rsp_rdata, 64'h0123_4567_89AB_CDEF);
      nxt();
      #1;
      chk("bp_f_grant", {d_req_ready, if_req_ready}, 2'b01);
      serve(64'h5555_6666_7777_8888);
      if_req_valid = 1'b0;
      chk("bp_f_data", if_rsp_data, 32'h7777_8888);

      // Reset while waiting for a response
      nxt();
      d_req_valid = 1'b1;
      d_req_addr  = 64'h400;
      #1;
      chk("rm_grant", d_req_ready, 1);
      nxt();
      d_req_valid   = 1'b0;
      mem_req_ready = 1'b1;
      #1;
      nxt();
      resetn      = 1'b0;
      d_req_valid = 1'b1;
      #1;
      chk("rm_mreq", {mem_req_valid, mem_req_we, mem_req_wstrb}, 0);
      chk("rm_addr", mem_req_addr, 0);
      chk("rm_ready", {d_req_ready, if_req_ready}, 0);
      chk("rm_rspv", {d_rsp_valid, if_rsp_valid}, 0);
      nxt();
      d_req_valid   = 1'b0;
      resetn        = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 64'h7777_7777_7777_7777;
      #1;
      chk("rm_late_rsp", {d_rsp_valid, if_rsp_valid}, 0);
      nxt();
      if_req_valid = 1'b1;
      if_req_addr  = 64'h8000_0004;
      #1;
      chk("rm_f_grant", if_req_ready, 1);
      serve(64'h9999_AAAA_BBBB_CCCC);
      if_req_valid = 1'b0;
      chk("rm_f_rsp", if_rsp_valid, 1);
      chk("rm_f_data", if_rsp_data, 32'h9999_AAAA);

      // Both requesters held valid: grant sequence
      nxt();
      if_req_valid = 1'b1;
      if_req_addr  = 64'h8000_0010;
      d_req_valid  = 1'b1;
      d_req_we     = 1'b0;
      d_req_addr   = 64'h300;
      #1;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin
            nxt();
            #1;
         end
`ifdef RISCV_ARB_STARVE_GUARD_EN
         exp_g = (i % 5 == 4) ? 2'b01 : 2'b10;
`else
         exp_g = 2'b10;
`endif
         chk("starve_grant", {d_req_ready, if_req_ready}, exp_g);
         serve(64'h1234_5678_9ABC_DEF0);
         chk("starve_rsp", {d_rsp_valid, if_rsp_valid}, exp_g);
      end
      nxt();
      if_req_valid = 1'b0;
      d_req_valid  = 1'b0;
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 The block SHALL take reset resetn, asynchronous, active-low, and clock clk.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4: the maximum number of consecutive data grants while a fetch is pending.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  clock
  resetn  in  1  async active-low reset
  if_req_valid  in  1  fetch request
  if_req_addr  in  64  fetch byte address, 4-byte aligned
  if_req_ready  out  1  fetch request accepted
  if_rsp_valid  out  1  fetch data valid
  if_rsp_data  out  32  instruction word
  d_req_valid  in  1  data request
  d_req_we  in  1  1 = store
  d_req_addr  in  64  data byte address
  d_req_wdata  in  64  store data
  d_req_wstrb  in  8  store byte enables
  d_req_ready  out  1  data request accepted
  d_rsp_valid  out  1  data response (load data or store ack)
  d_rsp_rdata  out  64  load data
  mem_req_valid  out  1  memory request
  mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb  out  1/64/64/8  registered request fields
  mem_req_ready  in  1  memory accepts request
  mem_rsp_valid  in  1  memory response
  mem_rsp_rdata  in  64  memory read data

Function
REQ-004 The block SHALL use a 3-state FSM: IDLE, REQ, WAIT_RSP; at most one transaction SHALL be outstanding.
REQ-005 In IDLE with at least one request valid, the block SHALL assert the winner's *_req_ready combinationally in that cycle, latch the winner's fields and owner ID, and enter REQ next cycle.
REQ-006 Grant priority SHALL be data over fetch, except as modified by REQ-015.
REQ-007 The loser's *_req_ready SHALL be 0; the loser SHALL remain pending without loss.
REQ-008 In IDLE with no request valid, the block SHALL stay in IDLE with mem_req_valid=0.
REQ-009 In REQ, mem_req_valid SHALL be 1 and the mem_req_* fields SHALL remain stable until mem_req_ready=1; the block SHALL then enter WAIT_RSP.
REQ-010 A fetch SHALL drive mem_req_we=0 and mem_req_wstrb=0.
REQ-011 In WAIT_RSP with mem_rsp_valid=1, the block SHALL pulse the owner's *_rsp_valid for exactly that cycle and return to IDLE next cycle.
REQ-012 The if_rsp_data output SHALL be mem_rsp_rdata[63:32] when latched addr[2]=1, else mem_rsp_rdata[31:0].
REQ-013 The non-owner's *_rsp_valid SHALL stay 0.
REQ-014 A mem_rsp_valid arriving in IDLE or REQ SHALL be ignored.
REQ-014a Minimum transaction latency SHALL be 3 cycles: accept, then request, then response, with zero memory wait.

Reset
REQ-016 On resetn=0, the block SHALL immediately force: state IDLE; all *_ready, *_valid and mem_req_* outputs 0; rsp data 0; starvation counter 0.
REQ-017 A transaction in flight at reset SHALL be abandoned, and no response SHALL be forwarded after reset release.
REQ-018 The first grant SHALL be possible in the first clk edge after resetn deasserts.

Configuration
REQ-015 With macro RISCV_ARB_STARVE_GUARD_EN defined:
  - A saturating counter SHALL count consecutive data grants made while if_req_valid=1.
  - When the counter equals STARVE_LIMIT, the next grant SHALL go to fetch, and the counter SHALL clear.
  - The counter SHALL also clear on any fetch grant, or on any data grant with if_req_valid=0.
  Without the macro, there SHALL be no counter, and strict data priority SHALL apply.

Verification
REQ-019 Fetch only:
  - Stimulus: if_req_addr=0x8000_0004; memory returns 0x1111_2222_3333_4444 with mem_req_ready=1 and a 1-cycle response.
  - Response: if_rsp_data=0x1111_2222, and if_rsp_valid is high 3 cycles after the request.
REQ-020 Simultaneous requests, fetch 0x8000_0000 and store 0x100 with wstrb=0x0F:
  - The data request SHALL be granted first, with mem_req_we=1 and mem_req_wstrb=0x0F.
  - The fetch SHALL be granted in the IDLE cycle after d_rsp_valid.
REQ-021 Backpressure: hold mem_req_ready=0 for 5 cycles.
  - mem_req_valid and all fields SHALL stay constant.
  - There SHALL be no new grant.
  - A stray mem_rsp_valid during REQ SHALL be ignored.
REQ-022 Starvation, with the macro and STARVE_LIMIT=4: keep both valid continuously.
  - Grant sequence SHALL be D,D,D,D,F,D,D,D,D,F.
  - Without the macro, the sequence SHALL be all D.
REQ-023 Reset mid-operation: assert resetn=0 in WAIT_RSP, then release.
  - All outputs SHALL be 0 immediately.
  - A late mem_rsp_valid SHALL produce no *_rsp_valid.
  - A new fetch SHALL then complete normally.
